// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between N iterative requesters.
//   Round-robin grant, registered ALU operands, captured result with a
//   one-cycle done pulse. A requester can lock the ALU across operations.
//   One operation takes 3 cycles: IDLE (grant) -> EXEC -> RETIRE.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_i[N]            per-requester request, held until its done_o pulse
//   lock_i[N]           per-requester lock, keeps ownership after completion
//   op_i/a_i/b_i        packed per-requester opcode / operands (slice i)
//   gnt_o[N]            one-hot current owner (0 when idle and unlocked)
//   done_o[N]           one-cycle pulse on owner's bit while res_o is valid
//   res_o               captured ALU result, held until next capture
//   busy_o              high in EXEC and RETIRE
//   alu_op_o/a_o/b_o    registered ALU inputs
//   alu_res_i           combinational ALU result
module alu_share_arbiter #(
  parameter int N   = 3,
  parameter int W   = 32,
  parameter int OPW = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic [N-1:0]     lock_i,
  input  logic [N*OPW-1:0] op_i,
  input  logic [N*W-1:0]   a_i,
  input  logic [N*W-1:0]   b_i,
  output logic [N-1:0]     gnt_o,
  output logic [N-1:0]     done_o,
  output logic [W-1:0]     res_o,
  output logic             busy_o,
  output logic [OPW-1:0]   alu_op_o,
  output logic [W-1:0]     alu_a_o,
  output logic [W-1:0]     alu_b_o,
  input  logic [W-1:0]     alu_res_i
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef struct packed {
    logic [OPW-1:0] op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } alu_req_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RETIRE} state_t;

  alu_req_t [N-1:0] req_pl;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign req_pl[g] = {op_i[g*OPW +: OPW], a_i[g*W +: W], b_i[g*W +: W]};
  end

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] own;      // requester whose operation is in flight
  logic          lock_vld;
  logic [IW-1:0] lock_id;

  // Lock only survives IDLE while its owner keeps lock_i high; dropping it
  // opens arbitration in the very same cycle.
  logic          lock_hold;
  logic [N-1:0]  elig;
  logic          win_vld;
  logic [IW-1:0] win_id;

  assign lock_hold = lock_vld && lock_i[lock_id];
  assign elig      = lock_hold ? (req_i & (ONE << lock_id)) : req_i;

  always_comb begin : p_scan
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!win_vld && elig[IW'(j)]) begin
        win_vld = 1'b1;
        win_id  = IW'(j);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      ptr      <= '0;
      own      <= '0;
      lock_vld <= 1'b0;
      lock_id  <= '0;
      gnt_o    <= '0;
      done_o   <= '0;
      res_o    <= '0;
      busy_o   <= 1'b0;
      alu_op_o <= '0;
      alu_a_o  <= '0;
      alu_b_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lock_vld && !lock_i[lock_id]) lock_vld <= 1'b0;
          if (win_vld) begin
            own                           <= win_id;
            gnt_o                         <= ONE << win_id;
            {alu_op_o, alu_a_o, alu_b_o}  <= req_pl[win_id];
            ptr                           <= (win_id == IW'(N-1)) ? '0 : win_id + 1'b1;
            busy_o                        <= 1'b1;
            state                         <= S_EXEC;
          end else begin
            gnt_o <= lock_hold ? (ONE << lock_id) : '0;
          end
        end
        S_EXEC: begin
          res_o  <= alu_res_i;
          done_o <= ONE << own;
          state  <= S_RETIRE;
        end
        S_RETIRE: begin
          done_o <= '0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
          if (lock_i[own]) begin
            lock_vld <= 1'b1;
            lock_id  <= own;
          end else begin
            lock_vld <= 1'b0;
            gnt_o    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one external combinational ALU between up to N iterative units, such as the shift-add multiplier, the square-root unit and the core datapath.
- Each requester presents an opcode and two operands and holds its request.
- The arbiter grants one requester at a time using round-robin order, drives the ALU from registered operands, captures the result, and returns it with a one-cycle done pulse.
- An optional per-requester lock lets a multi-step algorithm keep the ALU across consecutive operations.

Parameters:
- N, 3, number of requesters (2..4); requester i uses slice i of every packed bus.
- W, 32, operand and result width.
- OPW, 3, ALU opcode width.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N  per-requester request; held high until that requester's done_o pulse.
- lock_i  in  N  per-requester lock; keeps ownership of the ALU after completion.
- op_i  in  N*OPW  per-requester opcode; slice i is op_i[i*OPW +: OPW].
- a_i  in  N*W  per-requester operand A.
- b_i  in  N*W  per-requester operand B.
- gnt_o  out  N  one-hot current owner; all zero when idle and unlocked.
- done_o  out  N  one-cycle pulse on the owner's bit when res_o is valid.
- res_o  out  W  captured ALU result; holds its value until the next capture.
- busy_o  out  1  high in the EXEC and RETIRE states.
- alu_op_o  out  OPW  registered opcode to the ALU.
- alu_a_o  out  W  registered operand A to the ALU.
- alu_b_o  out  W  registered operand B to the ALU.
- alu_res_i  in  W  combinational ALU result for alu_op_o, alu_a_o and alu_b_o.

Behaviour:
- Reset (rst_i high at a clock edge):
  - state goes to IDLE; round-robin pointer ptr goes to 0; lock owner is cleared.
  - gnt_o, done_o, res_o, alu_op_o, alu_a_o, alu_b_o and busy_o all go to 0.
  - Reset overrides everything. An operation in flight is abandoned with no done_o pulse.
- State machine, one operation per 3 cycles:
  - IDLE:
    - If a lock owner L exists, only L is eligible; others are ignored even if requesting.
    - Otherwise the winner is the first requester with req_i high, scanning ptr, ptr+1, ... modulo N.
    - If there is a winner w: gnt_o <= onehot(w); alu_op_o, alu_a_o and alu_b_o <= slice w of op_i, a_i and b_i; ptr <= (w+1) mod N; go to EXEC.
    - If there is no eligible request: stay in IDLE. gnt_o shows the lock owner if one exists, otherwise 0.
  - EXEC:
    - The ALU evaluates the registered operands.
    - res_o <= alu_res_i; done_o[w] <= 1; go to RETIRE.
  - RETIRE:
    - done_o is high during this cycle; req_i is ignored.
    - If lock_i[w] is high, L <= w and gnt_o stays onehot(w); otherwise L is cleared and gnt_o <= 0.
    - done_o <= 0; go to IDLE.
- Requester rule: the requester sees done_o during RETIRE. By the edge that ends RETIRE it must deassert req_i or present its next operation.
- Latency: a request sampled at edge k gives ALU inputs valid in cycle k+1, res_o and done_o valid in cycle k+2, and the next grant at edge k+3.
- Operands are sampled only at the grant edge. Changes to req_i, op_i, a_i or b_i during EXEC or RETIRE do not affect the operation in flight. If req_i drops during EXEC, the operation still completes and done_o still pulses.
- A locked owner whose req_i is low while in IDLE keeps the grant and blocks all other requesters until it deasserts lock_i (observed in IDLE, which then clears L) or rst_i is asserted. Releasing the lock in IDLE with other requests pending grants by round-robin in that same cycle.
- Requester indices ≥ N do not exist. With N=2, ptr wraps 1 -> 0.
- alu_op_o, alu_a_o and alu_b_o hold their last values outside EXEC; no gating.
- Invariants:
  - done_o is at most one-hot, and is high only in RETIRE.
  - gnt_o is at most one-hot.

Test Plan:
- Reset, then req_i=3'b001, op=3'b000, a=7, b=5, ALU=add model → alu_a_o=7 in cycle 1; res_o=12 and done_o=3'b001 in cycle 2; busy_o low in cycle 3.
- req_i=3'b111 held, each requester re-requests right after its done → grant order 0,1,2,0 with 3 cycles each; done_o pulses at cycles 2, 5, 8, 11.
- Requester 1 asserts lock_i with req held for 4 operations while req 0 and req 2 are high → four consecutive grants to 1. After lock_i drops, the next grant goes to 2 (ptr=2), then 0.
- Lock held with req_i[1] low for 10 cycles while req_i[0] is high → gnt_o=3'b010, no done_o pulses, requester 0 starved. Releasing the lock grants requester 0 the same cycle.
- rst_i asserted during EXEC → no done_o pulse; next cycle all outputs are 0 and ptr=0.
- a_i changed from 7 to 99 during EXEC → res_o still reflects 7.
